// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and receiver state type, used by both the
// timing generator and the sync receiver.
package vga_timing_pkg;

    localparam logic [9:0] H_DISPLAY    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BACK       = 10'd48;
    localparam logic [9:0] H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam logic [9:0] H_MAX        = H_SYNC_START + H_SYNC + H_BACK - 10'd1;

    localparam logic [9:0] V_DISPLAY    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BACK       = 10'd33;
    localparam logic [9:0] V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
    localparam logic [9:0] V_MAX        = V_SYNC_START + V_SYNC + V_BACK - 10'd1;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync wire and flags its rising edge (current sample high, previous low).
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic q_o,
    output logic rise_o
);

    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_i;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_i & ~sync_q;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers (px,py) from hsync/vsync, verifies edge timing and locks.
// Optional frame/error statistics counters are built when VGA_SYNC_RX_STATS_EN is defined.
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int unsigned LOCK_LINES = 4,
    parameter int unsigned MISS_LINES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] px,
    output logic [8:0] py,
    output logic       visible,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);

    localparam int unsigned GW = $clog2(LOCK_LINES + 1);
    localparam int unsigned MW = $clog2(MISS_LINES + 1);

    logic            hs_q, vs_q, h_rise, v_rise;
    logic [9:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic            h_wrap, h_ok, v_ok;
    logic            seen_q, seen_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            miss_hit;
    logic [GW-1:0]   good_q, good_d;
    logic            vseen_q, vseen_d;
    rx_state_t       state_q, state_d;
    logic            locked_q, frame_start_q, sync_err_q;
    logic            sync_err_d;

    sync_edge_det u_hs_det (
        .clk    (clk),
        .reset  (reset),
        .sync_i (hsync_in),
        .q_o    (hs_q),
        .rise_o (h_rise)
    );

    sync_edge_det u_vs_det (
        .clk    (clk),
        .reset  (reset),
        .sync_i (vsync_in),
        .q_o    (vs_q),
        .rise_o (v_rise)
    );

    assign h_wrap = (hcnt_q == H_MAX) && !h_rise;
    assign h_ok   = (hcnt_q == H_SYNC_START);
    assign v_ok   = (vcnt_q == V_SYNC_START);

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        seen_d = seen_q;
        miss_d = miss_q;
        if (h_rise) begin
            hcnt_d = H_SYNC_START + 10'd1;
        end else if (h_wrap) begin
            hcnt_d = '0;
        end
        // vsync reload wins over the line increment of a coincident wrap
        if (v_rise) begin
            vcnt_d = V_SYNC_START;
        end else if (h_wrap) begin
            vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + 10'd1;
        end
        if (h_rise) begin
            seen_d = 1'b1;
            miss_d = '0;
        end else if (h_wrap) begin
            seen_d = 1'b0;
            if (!seen_q && miss_q != MW'(MISS_LINES)) begin
                miss_d = miss_q + 1'b1;
            end
        end
    end

    assign miss_hit = h_wrap && !seen_q && (miss_q >= MW'(MISS_LINES - 1));

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        vseen_d    = vseen_q;
        sync_err_d = 1'b0;
        case (state_q)
            SEARCH: begin
                good_d  = '0;
                vseen_d = 1'b0;
                if (h_rise) begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (v_rise) begin
                    vseen_d = 1'b1;
                end
                if (h_rise) begin
                    if (!h_ok) begin
                        good_d = '0;
                    end else if (vseen_q) begin
                        good_d = good_q + 1'b1;
                    end
                end
                if (good_d == GW'(LOCK_LINES)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if ((h_rise && !h_ok) || (v_rise && !v_ok) || miss_hit) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            seen_q        <= 1'b0;
            miss_q        <= '0;
            good_q        <= '0;
            vseen_q       <= 1'b0;
            state_q       <= SEARCH;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            seen_q        <= seen_d;
            miss_q        <= miss_d;
            good_q        <= good_d;
            vseen_q       <= vseen_d;
            state_q       <= state_d;
            locked_q      <= (state_d == LOCKED);
            frame_start_q <= (state_d == LOCKED) && (hcnt_d == '0) && (vcnt_d == '0);
            sync_err_q    <= sync_err_d;
        end
    end

    assign px          = hcnt_q;
    assign py          = vcnt_q[8:0];
    // qualified on the 9-bit py as presented, not the full line counter
    assign visible     = locked_q && (hcnt_q < H_DISPLAY) && ({1'b0, vcnt_q[8:0]} < V_DISPLAY);
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;

`ifdef VGA_SYNC_RX_STATS_EN
    logic [7:0] frame_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_start_q && frame_cnt_q != '1) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (sync_err_q && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx: a behavioural 640x480 generator drives registered
// hsync/vsync; the generator is repositioned near vsync while unlocked to keep runs short.
module tb_vga_sync_rx;

`ifdef VGA_SYNC_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in;
    logic [9:0] px;
    logic [8:0] py;
    logic       visible, locked, frame_start, sync_err;
    logic [7:0] frame_cnt, err_cnt;

    always #5 clk = ~clk;

    vga_sync_rx #(
        .LOCK_LINES (4),
        .MISS_LINES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .px          (px),
        .py          (py),
        .visible     (visible),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    int total = 0;
    int bad   = 0;

    // generator position; sync outputs are registered from it, so the receiver's
    // (px,py) observed after a clock equals the generator position about to be driven
    int hpos, vpos;
    int dly_line = -1;
    int mask_lo  = -1;
    int mask_hi  = -2;
    int fvs_v    = -1;
    int fvs_h    = -1;
    bit track    = 1'b0;

    task automatic check_eq(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (hpos=%0d vpos=%0d)", tag, act, exp, hpos, vpos);
        end
    endtask

    task automatic track_checks();
        check_eq("trk_px", int'(px), hpos);
        check_eq("trk_py", int'(py), vpos % 512);
        check_eq("trk_vis", int'(visible), int'(hpos < 640 && (vpos % 512) < 480));
        check_eq("trk_fs", int'(frame_start), int'(hpos == 0 && vpos == 0));
        check_eq("trk_lock", int'(locked), 1);
    endtask

    task automatic drive_step();
        bit hs, vs;
        if (vpos == dly_line) hs = (hpos >= 659 && hpos <= 754);
        else                  hs = (hpos >= 656 && hpos <= 751);
        if (vpos >= mask_lo && vpos <= mask_hi) hs = 1'b0;
        vs = (vpos >= 490 && vpos <= 491);
        if (vpos == fvs_v && hpos == fvs_h) vs = 1'b1;
        hsync_in = hs;
        vsync_in = vs;
        if (hpos == 799) begin
            hpos = 0;
            vpos = (vpos == 524) ? 0 : vpos + 1;
        end else begin
            hpos++;
        end
    endtask

    task automatic tick();
        if (track) track_checks();
        drive_step();
        @(negedge clk);
    endtask

    task automatic wait_at(input string tag, input int h, input int v, input int budget);
        int n = 0;
        while (!(hpos == h && vpos == v) && n < budget) begin
            tick();
            n++;
        end
        check_eq({"reach_", tag}, int'(hpos == h && vpos == v), 1);
    endtask

    task automatic scan(input int ncyc, output int errs, output int eh, output int ev,
                        output int epx, output int epy, output int elk);
        errs = 0; eh = -1; ev = -1; epx = -1; epy = -1; elk = -1;
        for (int i = 0; i < ncyc; i++) begin
            if (sync_err) begin
                errs++;
                if (errs == 1) begin
                    eh = hpos; ev = vpos; epx = int'(px); epy = int'(py); elk = int'(locked);
                end
            end
            tick();
        end
    endtask

    // lock needs vsync at line 490 then good hsync edges on lines 490..493
    task automatic relock_check(input string tag, input int nerr);
        wait_at({tag, "_l493"}, 0, 493, 8 * 800);
        check_eq({tag, "_unlocked"}, int'(locked), 0);
        tick();
        wait_at({tag, "_l494"}, 0, 494, 810);
        check_eq({tag, "_locked"}, int'(locked), 1);
        check_eq({tag, "_errcnt"}, int'(err_cnt), STATS ? nerr : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int errs, eh, ev, epx, epy, elk;
        reset = 1'b1;
        hpos  = 0;
        vpos  = 489;
        drive_step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();

        check_eq("rst_px", int'(px), 0);
        check_eq("rst_py", int'(py), 0);
        check_eq("rst_vis", int'(visible), 0);
        check_eq("rst_lock", int'(locked), 0);
        check_eq("rst_fs", int'(frame_start), 0);
        check_eq("rst_err", int'(sync_err), 0);
        check_eq("rst_fcnt", int'(frame_cnt), 0);
        check_eq("rst_ecnt", int'(err_cnt), 0);
        reset = 1'b0;

        relock_check("lock0", 0);

        // one hsync pulse 3 clocks late on line 494
        dly_line = 494;
        scan(800, errs, eh, ev, epx, epy, elk);
        dly_line = -1;
        check_eq("dly_errs", errs, 1);
        check_eq("dly_err_h", eh, 660);
        check_eq("dly_err_px", epx, 657);
        check_eq("dly_locked", elk, 0);
        hpos = 0; vpos = 489;
        relock_check("dly_relock", 1);

        // hsync missing for lines 495 and 496
        mask_lo = 495; mask_hi = 496;
        scan(3 * 800 + 10, errs, eh, ev, epx, epy, elk);
        mask_lo = -1; mask_hi = -2;
        check_eq("wd_errs", errs, 1);
        check_eq("wd_err_h", eh, 0);
        check_eq("wd_err_v", ev, 497);
        check_eq("wd_err_px", epx, 0);
        check_eq("wd_err_py", epy, 497);
        check_eq("wd_locked", elk, 0);
        hpos = 0; vpos = 489;
        relock_check("wd_relock", 2);

        // stray vsync rise at the last pixel of line 496
        fvs_v = 496; fvs_h = 799;
        scan(3 * 800 + 10, errs, eh, ev, epx, epy, elk);
        fvs_v = -1; fvs_h = -1;
        check_eq("vs_errs", errs, 1);
        check_eq("vs_err_h", eh, 0);
        check_eq("vs_err_v", ev, 497);
        check_eq("vs_err_px", epx, 0);
        check_eq("vs_err_py", epy, 490);
        check_eq("vs_locked", elk, 0);
        hpos = 0; vpos = 489;
        relock_check("vs_relock", 3);

        // cycle-by-cycle tracking across the frame boundary
        track = 1'b1;
        wait_at("trk_end", 320, 1, 33 * 800);
        track = 1'b0;
        check_eq("pre_rst_vis", int'(visible), 1);
        check_eq("pre_rst_px", int'(px), 320);
        check_eq("pre_rst_fcnt", int'(frame_cnt), STATS ? 1 : 0);
        check_eq("pre_rst_ecnt", int'(err_cnt), STATS ? 3 : 0);

        reset = 1'b1;
        tick();
        check_eq("mid_rst_px", int'(px), 0);
        check_eq("mid_rst_py", int'(py), 0);
        check_eq("mid_rst_lock", int'(locked), 0);
        check_eq("mid_rst_vis", int'(visible), 0);
        check_eq("mid_rst_err", int'(sync_err), 0);
        check_eq("mid_rst_fs", int'(frame_start), 0);
        check_eq("mid_rst_fcnt", int'(frame_cnt), 0);
        check_eq("mid_rst_ecnt", int'(err_cnt), 0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
